dac_level_mc: RTL
=================

DAC_LEVEL_MC -- requirements
Module: dac_level_mc

Interface
REQ-001 Parameter CH, default 4, number of parallel DAC serial data lines sharing one chip select and one SCLK.
REQ-002 Parameter DW, default 8, bits per DAC word, sent MSB first.
REQ-003 Parameter DLY_W, default 7, width of the programmable sync-delay value and counter.
REQ-004 Parameter DIV, default 1, range >= 1, clk cycles per SCLK half-period.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_sync  input  1  frame sync, synchronous to clk; its rising edge is the trigger.
REQ-008 i_dac_data  input  CH*DW  channel words, channel k at bits [k*DW+DW-1 : k*DW].
REQ-009 i_delay  input  DLY_W  sync-delay value in clk cycles.
REQ-010 o_dac_data  output  CH  serial data, bit k for channel k.
REQ-011 o_dac_sclk  output  1  shared serial clock; DAC samples on its rising edge.
REQ-012 o_dac_cs_n  output  1  shared active-low chip select.
REQ-013 o_sync_delayed  output  1  one-clk pulse i_delay+1 cycles after a trigger.
REQ-014 o_busy  output  1  high while a serial frame is in progress.
REQ-015 o_overrun  output  1  one-clk pulse when a trigger arrives while o_busy is high.

Function
REQ-016 Trigger: registered copy of i_sync; trigger at cycle T when i_sync=1 and the registered copy is 0.
REQ-017 State machine IDLE -> SLO -> SHI -> (SLO | GAP) -> IDLE; all outputs registered.
REQ-018 IDLE + trigger at T: latch all CH*DW bits of i_dac_data into shift registers and enter SLO; at T+1: cs_n=0, sclk=0, o_busy=1, o_dac_data = MSB of each channel.
REQ-019 SLO lasts DIV cycles with sclk=0, then SHI lasts DIV cycles with sclk=1; o_dac_data changes only on SHI->SLO transitions, never while sclk=1.
REQ-020 After the DW-th SHI, enter GAP: cs_n=1, sclk=0, data=0 for exactly 1 cycle; then IDLE, o_busy=0.
REQ-021 Frame length: cs_n low for exactly 2*DIV*DW cycles; o_busy high for 2*DIV*DW+1 cycles starting T+1.
REQ-022 Bit counter width ceil(log2(DW+1)); DIV counter width ceil(log2(DIV+1)); no wrap inside a frame.
REQ-023 Trigger in any state other than IDLE: frame not restarted, latched data unchanged, o_overrun=1 at T+1.
REQ-024 Trigger in GAP counts as overrun; a trigger in the IDLE cycle directly after GAP starts a new frame.
REQ-025 Delay path independent of the frame: at every trigger (IDLE or not) capture i_delay and clear the delay counter; o_sync_delayed=1 exactly at cycle T+1+captured_delay.
REQ-026 Delay counter saturates after the pulse; no further pulse until the next trigger.
REQ-027 Trigger while a delay is pending: restart with the newly captured delay; the pending pulse is dropped.
REQ-028 i_delay=0: o_sync_delayed pulses at T+1; i_delay=2^DLY_W-1: pulses at T+2^DLY_W.
REQ-029 Changes on i_dac_data or i_delay after T have no effect on the current frame or delay.

Reset
REQ-030 rst=1 at a clk edge: state IDLE, cs_n=1, sclk=0, o_dac_data=0, o_busy=0, o_overrun=0, o_sync_delayed=0, delay counter saturated (no pending pulse), registered sync copy=0.
REQ-031 rst mid-frame aborts the frame (cs_n=1 on the next cycle); rst mid-delay cancels the pending pulse.
REQ-032 i_sync held high through reset release counts as a trigger on the first cycle after release.

Verification
REQ-033 CH=4, DW=8, DIV=1, data {0xA5,0x3C,0xFF,0x00} on ch0..3, one trigger -> cs_n low for 16 cycles; rising-SCLK samples give ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00; o_busy high for 17 cycles.
REQ-034 DIV=3, DW=8 -> SCLK period 6 clk, cs_n low for 48 cycles, data stable through each sclk=1 phase.
REQ-035 i_delay=10, trigger at T -> o_sync_delayed single pulse at T+11; i_delay=0 -> pulse at T+1.
REQ-036 Second trigger 5 cycles into a frame with i_delay=20 -> o_overrun pulse, serial data unaffected; delayed pulse only at second-trigger time +21, none from the first trigger.
REQ-037 rst asserted 7 cycles into a frame -> cs_n=1, sclk=0, o_busy=0 next cycle; no o_sync_delayed pulse follows.
REQ-038 Trigger in the first IDLE cycle after GAP -> new frame starts, no overrun.

Source files
------------

// File: rtl/dac_level_mc.sv
// Multi-channel serial DAC loader: one frame-sync trigger shifts CH words out MSB first
// on a shared SCLK/CS_N, alongside an independent programmable sync-delay pulse.
module dac_level_mc #(
    parameter int CH    = 4,
    parameter int DW    = 8,
    parameter int DLY_W = 7,
    parameter int DIV   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sync,
    input  logic [CH*DW-1:0]    i_dac_data,
    input  logic [DLY_W-1:0]    i_delay,
    output logic [CH-1:0]       o_dac_data,
    output logic                o_dac_sclk,
    output logic                o_dac_cs_n,
    output logic                o_sync_delayed,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam int BW  = $clog2(DW + 1);
    localparam int DVW = $clog2(DIV + 1);
    localparam int CW  = DLY_W + 1;
    localparam logic [BW-1:0]  BIT_LAST = BW'(DW - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_SAT  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLO  = 2'd1,
        S_SHI  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    sync_q;
    logic                    cs_n_q;
    logic                    sclk_q;
    logic                    busy_q;
    logic                    ovr_q;
    logic [CH-1:0]           data_q;
    logic [BW-1:0]           bit_q;
    logic [DVW-1:0]          div_q;
    // The MSB goes straight to data_q on load, so only the remaining DW-1 bits are held.
    logic [CH-1:0][DW-2:0]   shreg_q;

    logic [DLY_W-1:0]        dly_val_q, dly_val_d;
    logic [CW-1:0]           dly_cnt_q, dly_cnt_d;
    logic                    pulse_q, pulse_d;
    logic                    sync_rise;

    assign sync_rise = i_sync & ~sync_q;

    // Serial frame state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= {CH{1'b0}};
            bit_q   <= {BW{1'b0}};
            div_q   <= {DVW{1'b0}};
            shreg_q <= {(CH*(DW-1)){1'b0}};
        end else begin
            sync_q <= i_sync;
            ovr_q  <= sync_rise & busy_q;
            case (state_q)
                S_IDLE: begin
                    if (sync_rise) begin
                        state_q <= S_SLO;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= {BW{1'b0}};
                        div_q   <= {DVW{1'b0}};
                        for (int k = 0; k < CH; k++) begin
                            data_q[k]  <= i_dac_data[k*DW + DW - 1];
                            shreg_q[k] <= i_dac_data[k*DW +: (DW-1)];
                        end
                    end
                end
                S_SLO: begin
                    if (div_q == DIV_LAST) begin
                        state_q <= S_SHI;
                        sclk_q  <= 1'b1;
                        div_q   <= {DVW{1'b0}};
                    end else begin
                        div_q <= div_q + DVW'(1);
                    end
                end
                S_SHI: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= {DVW{1'b0}};
                        sclk_q <= 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= S_GAP;
                            cs_n_q  <= 1'b1;
                            data_q  <= {CH{1'b0}};
                        end else begin
                            state_q <= S_SLO;
                            bit_q   <= bit_q + BW'(1);
                            for (int k = 0; k < CH; k++) begin
                                data_q[k]  <= shreg_q[k][DW-2];
                                shreg_q[k] <= shreg_q[k] << 1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DVW'(1);
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    data_q  <= {CH{1'b0}};
                end
            endcase
        end
    end

    // Sync-delay next state: every trigger restarts the count; a zero delay fires at once.
    always_comb begin
        dly_val_d = dly_val_q;
        dly_cnt_d = dly_cnt_q;
        pulse_d   = 1'b0;
        if (sync_rise) begin
            dly_val_d = i_delay;
            if (i_delay == {DLY_W{1'b0}}) begin
                pulse_d   = 1'b1;
                dly_cnt_d = CNT_SAT;
            end else begin
                dly_cnt_d = {CW{1'b0}};
            end
        end else if (dly_cnt_q != CNT_SAT) begin
            if (dly_cnt_q == ({1'b0, dly_val_q} - CW'(1))) begin
                pulse_d   = 1'b1;
                dly_cnt_d = CNT_SAT;
            end else begin
                dly_cnt_d = dly_cnt_q + CW'(1);
            end
        end else begin
            dly_cnt_d = CNT_SAT;
        end
    end

    // Sync-delay registers; the saturated count means nothing is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_val_q <= {DLY_W{1'b0}};
            dly_cnt_q <= CNT_SAT;
            pulse_q   <= 1'b0;
        end else begin
            dly_val_q <= dly_val_d;
            dly_cnt_q <= dly_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign o_dac_data     = data_q;
    assign o_dac_sclk     = sclk_q;
    assign o_dac_cs_n     = cs_n_q;
    assign o_busy         = busy_q;
    assign o_overrun      = ovr_q;
    assign o_sync_delayed = pulse_q;

endmodule
